// File: rtl/wbsdram_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SDRAM controller slave port.
// Round-robin grant per bus cycle, outstanding-request tracking so responses
// reach only the owner, and preemption of an owner idling on the bus.
module wbsdram_arbiter #(
  parameter int AW           = 26,
  parameter int DW           = 32,
  parameter int LGOUT        = 5,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rd_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [LGOUT-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0]    IDLE_END = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state, state_nxt;
  logic             last_b, last_b_nxt;
  logic [LGOUT-1:0] count, count_nxt;
  logic [IW-1:0]    idle_cnt, idle_nxt;

  logic own_cyc, own_stb, other_cyc;
  logic sat, resp_ok, accept, respond;

  // Read data is a plain passthrough, held at zero while in reset.
  assign o_rd_data = i_reset ? '0 : i_wb_data;

  // Owner mux: route the granted master to the slave and the slave's responses back.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    other_cyc = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_a_stall = 1'b1;
    o_b_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    sat       = (count == CNT_MAX);
    resp_ok   = (count != '0);
    case (state)
      OWN_A: begin
        own_cyc   = i_a_cyc;
        own_stb   = i_a_stb;
        other_cyc = i_b_cyc;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        o_a_stall = i_wb_stall || sat;
        o_a_ack   = i_wb_ack && i_a_cyc && resp_ok;
        o_a_err   = i_wb_err && i_a_cyc && resp_ok;
      end
      OWN_B: begin
        own_cyc   = i_b_cyc;
        own_stb   = i_b_stb;
        other_cyc = i_a_cyc;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
        o_b_stall = i_wb_stall || sat;
        o_b_ack   = i_wb_ack && i_b_cyc && resp_ok;
        o_b_err   = i_wb_err && i_b_cyc && resp_ok;
      end
      default: ;
    endcase
    o_wb_cyc = own_cyc;
    o_wb_stb = own_cyc && own_stb && !sat;
    accept   = o_wb_stb && !i_wb_stall;
    respond  = (i_wb_ack || i_wb_err) && resp_ok;
  end

  // Next-state: round-robin grant, outstanding count, release and idle preemption.
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    count_nxt  = count;
    idle_nxt   = '0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (i_a_cyc && (!i_b_cyc || last_b)) begin
          state_nxt  = OWN_A;
          last_b_nxt = 1'b0;
        end else if (i_b_cyc) begin
          state_nxt  = OWN_B;
          last_b_nxt = 1'b1;
        end
      end
      default: begin
        // Release wins over preemption; both paths clear count and idle counter.
        if (!own_cyc) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          case ({accept, respond})
            2'b10:   count_nxt = count + LGOUT'(1);
            2'b01:   count_nxt = count - LGOUT'(1);
            default: count_nxt = count;
          endcase
          if (!own_stb && !resp_ok && other_cyc) begin
            if (idle_cnt == IDLE_END) state_nxt = IDLE;
            else                      idle_nxt  = idle_cnt + IW'(1);
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset; last_owner resets to B so A wins the first tie.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      count    <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      count    <= count_nxt;
      idle_cnt <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_wbsdram_arbiter.sv
// Directed bench for wbsdram_arbiter (LGOUT=2, IDLE_TIMEOUT=4) with a
// scoreboard: expected slave requests and master responses are queued by
// the stimulus and popped by a negedge monitor.
module tb_wbsdram_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    sel;
  } req_t;

  typedef struct {
    logic [3:0]    flags;  // {a_ack, a_err, b_ack, b_err}
    logic [DW-1:0] data;
  } rsp_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_a_cyc = 1'b0, i_a_stb = 1'b0, i_a_we = 1'b0;
  logic [AW-1:0] i_a_addr = '0;
  logic [DW-1:0] i_a_data = '0;
  logic [3:0]    i_a_sel = 4'hF;
  logic          i_b_cyc = 1'b0, i_b_stb = 1'b0, i_b_we = 1'b0;
  logic [AW-1:0] i_b_addr = '0;
  logic [DW-1:0] i_b_data = '0;
  logic [3:0]    i_b_sel = 4'h3;
  logic          i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [DW-1:0] i_wb_data = '0;
  logic          o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0] o_rd_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [3:0]    o_wb_sel;

  int   n_tests = 0;
  int   n_fail  = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mon_req;
  rsp_t mon_rsp;

  wbsdram_arbiter #(.AW(AW), .DW(DW), .LGOUT(2), .IDLE_TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
    .o_rd_data(o_rd_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_a(input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    i_a_cyc = cyc; i_a_stb = stb; i_a_we = we; i_a_addr = addr; i_a_data = data;
  endtask

  task automatic set_b(input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    i_b_cyc = cyc; i_b_stb = stb; i_b_we = we; i_b_addr = addr; i_b_data = data;
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [3:0] sel);
    req_t r;
    r.we = we; r.addr = addr; r.data = data; r.sel = sel;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input logic [3:0] flags, input logic [DW-1:0] data);
    rsp_t r;
    r.flags = flags; r.data = data;
    exp_rsp.push_back(r);
  endtask

  // Monitor: every accepted slave strobe and every routed response is scored.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_wb_stb && !i_wb_stall) begin
        if (exp_req.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: addr %0h accepted, none expected", o_wb_addr);
        end else begin
          mon_req = exp_req.pop_front();
          check("req_addr", 64'(o_wb_addr), 64'(mon_req.addr));
          check("req_we", 64'(o_wb_we), 64'(mon_req.we));
          check("req_sel", 64'(o_wb_sel), 64'(mon_req.sel));
          if (mon_req.we) check("req_data", 64'(o_wb_data), 64'(mon_req.data));
        end
      end
      if (o_a_ack || o_a_err || o_b_ack || o_b_err) begin
        if (exp_rsp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: flags %b routed, none expected",
                   {o_a_ack, o_a_err, o_b_ack, o_b_err});
        end else begin
          mon_rsp = exp_rsp.pop_front();
          check("rsp_route", 64'({o_a_ack, o_a_err, o_b_ack, o_b_err}), 64'(mon_rsp.flags));
          check("rsp_data", 64'(o_rd_data), 64'(mon_rsp.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values hold while reset is high, even with live inputs.
    #1 i_reset = 1'b1;
    i_wb_data = 32'hDEAD_BEEF; i_wb_ack = 1'b1;
    set_a(1, 1, 1, 26'h3, 32'h1);
    #2;
    check("rst_a_stall", 64'(o_a_stall), 64'd1);
    check("rst_b_stall", 64'(o_b_stall), 64'd1);
    check("rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
    check("rst_wb_stb", 64'(o_wb_stb), 64'd0);
    check("rst_wb_addr", 64'(o_wb_addr), 64'd0);
    check("rst_rd_data", 64'(o_rd_data), 64'd0);
    check("rst_a_ack", 64'(o_a_ack), 64'd0);
    tick(); tick();
    i_wb_ack = 1'b0; i_wb_data = '0;
    set_a(0, 0, 0, '0, '0);
    i_reset = 1'b0;
    tick();

    // Single read from A, one slave stall cycle, ack three cycles after issue.
    set_a(1, 1, 0, 26'h10, '0);
    push_req(0, 26'h10, '0, 4'hF);
    #1 check("t1_stb_in_idle", 64'(o_wb_stb), 64'd0);
    tick();
    check("t1_stb_after_grant", 64'(o_wb_stb), 64'd1);
    i_wb_stall = 1'b1;
    #1 check("t1_stall_pass", 64'(o_a_stall), 64'd1);
    tick();
    i_wb_stall = 1'b0;
    tick();
    i_a_stb = 1'b0;
    tick(); tick();
    i_wb_ack = 1'b1; i_wb_data = 32'hCAFE_0010;
    push_rsp(4'b1000, 32'hCAFE_0010);
    #1 check("t1_b_ack_quiet", 64'(o_b_ack), 64'd0);
    tick();
    i_wb_ack = 1'b0; i_a_cyc = 1'b0;
    tick();

    // Tie every round: fresh from reset A wins, then grants alternate.
    i_reset = 1'b1; tick(); i_reset = 1'b0; tick();
    for (int unsigned r = 0; r < 4; r++) begin
      set_a(1, 1, 1, 26'('h100 + r), 32'hA000_0000 + r);
      set_b(1, 1, 1, 26'('h200 + r), 32'hB000_0000 + r);
      push_req(1, 26'('h100 + r), 32'hA000_0000 + r, 4'hF);
      push_req(1, 26'('h200 + r), 32'hB000_0000 + r, 4'h3);
      tick();
      check("t2_b_stall_while_a", 64'(o_b_stall), 64'd1);
      tick();
      i_a_stb = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h1000 + r;
      push_rsp(4'b1000, 32'h1000 + r);
      tick();
      i_wb_ack = 1'b0; i_a_cyc = 1'b0;
      tick();
      check("t2_cyc_gap", 64'(o_wb_cyc), 64'd0);
      tick(); tick();
      i_b_stb = 1'b0; i_wb_data = 32'h2000 + r;
      if (r == 3) begin i_wb_err = 1'b1; push_rsp(4'b0001, 32'h2000 + r); end
      else        begin i_wb_ack = 1'b1; push_rsp(4'b0010, 32'h2000 + r); end
      tick();
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_b_cyc = 1'b0;
      tick();
    end

    // Saturation at 3 outstanding; one ack frees exactly one more slot.
    set_a(1, 1, 0, 26'h300, '0);
    push_req(0, 26'h300, '0, 4'hF);
    tick(); tick();
    i_a_addr = 26'h301; push_req(0, 26'h301, '0, 4'hF);
    tick();
    i_a_addr = 26'h302; push_req(0, 26'h302, '0, 4'hF);
    tick();
    i_a_addr = 26'h303;
    #1 check("t3_sat_stall", 64'(o_a_stall), 64'd1);
    check("t3_sat_stb_low", 64'(o_wb_stb), 64'd0);
    tick();
    i_wb_ack = 1'b1; i_wb_data = 32'h3;
    push_rsp(4'b1000, 32'h3);
    tick();
    i_wb_ack = 1'b0;
    push_req(0, 26'h303, '0, 4'hF);
    #1 check("t3_slot_free", 64'(o_a_stall), 64'd0);
    tick();
    check("t3_resat_stall", 64'(o_a_stall), 64'd1);
    check("t3_resat_stb_low", 64'(o_wb_stb), 64'd0);
    set_a(0, 0, 0, '0, '0);
    tick();

    // Preemption: A idles with nothing outstanding while B waits.
    set_a(1, 0, 0, 26'h4FF, '0);
    tick();
    set_b(1, 1, 1, 26'h400, 32'hB400);
    for (int unsigned i = 0; i < 4; i++) begin
      #1 check("t4_still_owned", 64'(o_wb_cyc), 64'd1);
      tick();
    end
    check("t4_preempted", 64'(o_wb_cyc), 64'd0);
    i_a_stb = 1'b1;
    #1 check("t4_preempted_stall", 64'(o_a_stall), 64'd1);
    push_req(1, 26'h400, 32'hB400, 4'h3);
    tick();
    check("t4_a_stall_b_owns", 64'(o_a_stall), 64'd1);
    check("t4_b_granted", 64'(o_b_stall), 64'd0);
    tick();
    i_b_stb = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h4;
    push_rsp(4'b0010, 32'h4);
    tick();
    i_wb_ack = 1'b0; i_b_cyc = 1'b0;
    tick();
    push_req(0, 26'h4FF, '0, 4'hF);
    tick();
    i_b_cyc = 1'b1;
    tick();
    i_a_stb = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      #1 check("t4_no_preempt_cnt1", 64'(o_wb_cyc), 64'd1);
      tick();
    end
    i_wb_ack = 1'b1; i_wb_data = 32'h44;
    push_rsp(4'b1000, 32'h44);
    tick();
    i_wb_ack = 1'b0; i_a_cyc = 1'b0; i_b_cyc = 1'b0;
    tick();

    // Abort with two outstanding, then a stray ack at count 0 goes nowhere.
    set_a(1, 1, 0, 26'h500, '0);
    push_req(0, 26'h500, '0, 4'hF);
    tick(); tick();
    i_a_addr = 26'h501; push_req(0, 26'h501, '0, 4'hF);
    tick();
    set_a(0, 0, 0, '0, '0);
    #1 check("t5_abort_cyc_low", 64'(o_wb_cyc), 64'd0);
    tick();
    check("t5_idle_stall", 64'(o_a_stall), 64'd1);
    i_a_cyc = 1'b1;
    tick();
    i_wb_ack = 1'b1;
    #1 check("t5_stray_a_ack", 64'(o_a_ack), 64'd0);
    check("t5_stray_b_ack", 64'(o_b_ack), 64'd0);
    tick();
    i_wb_ack = 1'b0; i_a_cyc = 1'b0;
    tick();

    // Async reset while B owns the bus mid-burst.
    set_b(1, 1, 0, 26'h600, '0);
    push_req(0, 26'h600, '0, 4'h3);
    tick(); tick();
    i_b_addr = 26'h601; push_req(0, 26'h601, '0, 4'h3);
    tick();
    i_b_addr = 26'h602;
    #1 i_reset = 1'b1;
    #1 check("t6_rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
    check("t6_rst_a_stall", 64'(o_a_stall), 64'd1);
    check("t6_rst_b_stall", 64'(o_b_stall), 64'd1);
    set_a(1, 1, 0, 26'h700, '0);
    tick(); tick();
    i_reset = 1'b0;
    push_req(0, 26'h700, '0, 4'hF);
    tick();
    check("t6_a_first_b_stall", 64'(o_b_stall), 64'd1);
    tick();
    i_a_stb = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h7;
    push_rsp(4'b1000, 32'h7);
    tick();
    i_wb_ack = 1'b0; i_a_cyc = 1'b0; i_b_cyc = 1'b0; i_b_stb = 1'b0;
    tick(); tick();

    check("req_queue_drained", 64'(exp_req.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
